// File: rtl/tea_pkg.sv
// Shared constants and the FIFO entry layout for the TEA pipeline scheduler.
package tea_pkg;

    localparam logic [31:0] DELTA       = 32'h9E3779B9;
    localparam int          BLOCK_W     = 64;
    localparam int          KEY_W       = 128;
    localparam int          TEA_ROUNDS  = 32;
    localparam int          TEA_LATENCY = TEA_ROUNDS + 1;

    typedef struct packed {
        logic               src;
        logic [BLOCK_W-1:0] ct;
    } fifo_entry_t;

endpackage

// File: rtl/tea_sched_fifo.sv
// First-word fall-through FIFO holding {src, ciphertext} blocks for the consumer.
module tea_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign rd_valid = (count_q != '0);
    // Head is forced to zero when empty so stale entries never show on the port.
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(wr_en && full && !rd_en));
    end

endmodule

// File: rtl/tea_pipe_sched.sv
// Round-robin scheduler sharing one no-stall TEA pipeline between two requesters,
// with credit-based flow control so every issued block has a reserved FIFO slot.
module tea_pipe_sched
    import tea_pkg::*;
#(
    parameter int ROUNDS     = TEA_ROUNDS,
    parameter int LATENCY    = ROUNDS + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s0_valid,
    output logic               s0_ready,
    input  logic [BLOCK_W-1:0] s0_plaintext,
    input  logic [KEY_W-1:0]   s0_key,
    input  logic               s1_valid,
    output logic               s1_ready,
    input  logic [BLOCK_W-1:0] s1_plaintext,
    input  logic [KEY_W-1:0]   s1_key,
    output logic [BLOCK_W-1:0] core_plaintext,
    output logic [KEY_W-1:0]   core_key,
    input  logic [BLOCK_W-1:0] core_ciphertext,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BLOCK_W-1:0] m_ciphertext,
    output logic               m_src,
    output logic               busy
);

    localparam int             CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  CREDITS_MAX = CW'(FIFO_DEPTH);

    logic               rr_q, rr_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] src_q, src_d;
    logic [BLOCK_W-1:0] pt_q, pt_d;
    logic [KEY_W-1:0]   key_q, key_d;

    logic               any_req, grant_id, issue, pop, fifo_valid;
    fifo_entry_t        wr_entry, head;

    // On a tie the requester that did not win last time is granted; a lone requester always wins.
    always_comb begin
        any_req  = s0_valid | s1_valid;
        grant_id = (s0_valid && s1_valid) ? ~rr_q : s1_valid;
        issue    = rst_n && any_req && (credits_q != '0);
        s0_ready = issue && !grant_id;
        s1_ready = issue && grant_id;

        core_plaintext = pt_q;
        core_key       = key_q;
        if (issue) begin
            core_plaintext = grant_id ? s1_plaintext : s0_plaintext;
            core_key       = grant_id ? s1_key       : s0_key;
        end
        pt_d  = core_plaintext;
        key_d = core_key;
        rr_d  = issue ? grant_id : rr_q;

        vld_d = {vld_q[LATENCY-2:0], issue};
        src_d = {src_q[LATENCY-2:0], grant_id};

        pop = fifo_valid && m_ready;
        case ({issue, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= 1'b1;
            credits_q <= CREDITS_MAX;
            vld_q     <= '0;
            src_q     <= '0;
            pt_q      <= '0;
            key_q     <= '0;
        end else begin
            rr_q      <= rr_d;
            credits_q <= credits_d;
            vld_q     <= vld_d;
            src_q     <= src_d;
            pt_q      <= pt_d;
            key_q     <= key_d;
        end
    end

    // The tail of the tracking register lines up with the core output in the same cycle.
    assign wr_entry = '{src: src_q[LATENCY-1], ct: core_ciphertext};

    tea_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (vld_q[LATENCY-1]),
        .wr_data  (wr_entry),
        .rd_en    (pop),
        .rd_valid (fifo_valid),
        .rd_data  (head)
    );

    assign m_valid      = fifo_valid;
    assign m_ciphertext = head.ct;
    assign m_src        = head.src;
    assign busy         = (credits_q != CREDITS_MAX);

endmodule

// File: tb/tb_tea_pipe_sched.sv
// Directed bench for tea_pipe_sched with a behavioural 33-cycle TEA core beside it.
module tb_tea_pipe_sched;

    localparam int LAT = 33;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s0_valid = 1'b0, s1_valid = 1'b0, m_ready = 1'b0;
    logic [63:0]  s0_plaintext = '0, s1_plaintext = '0;
    logic [127:0] s0_key = '0, s1_key = '0;
    logic         s0_ready, s1_ready, m_valid, m_src, busy;
    logic [63:0]  core_plaintext, core_ciphertext, m_ciphertext;
    logic [127:0] core_key;

    int           checks = 0;
    int           failures = 0;
    int           pop_count = 0;
    logic [64:0]  exp_q[$];
    logic [63:0]  core_pipe [LAT];

    tea_pipe_sched dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_plaintext(s0_plaintext), .s0_key(s0_key),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_plaintext(s1_plaintext), .s1_key(s1_key),
        .core_plaintext(core_plaintext), .core_key(core_key), .core_ciphertext(core_ciphertext),
        .m_valid(m_valid), .m_ready(m_ready), .m_ciphertext(m_ciphertext), .m_src(m_src),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] teaEncrypt(input logic [63:0] pt, input logic [127:0] key);
        logic [31:0] v0, v1, sum;
        v0 = pt[63:32];
        v1 = pt[31:0];
        sum = '0;
        for (int r = 0; r < 32; r++) begin
            sum = sum + 32'h9E3779B9;
            v0 = v0 + ((((v1 << 4) + key[127:96]) ^ (v1 + sum)) ^ ((v1 >> 5) + key[95:64]));
            v1 = v1 + ((((v0 << 4) + key[63:32]) ^ (v0 + sum)) ^ ((v0 >> 5) + key[31:0]));
        end
        return {v0, v1};
    endfunction

    // Core input register plus 32 round stages: result appears LAT cycles after sampling.
    always @(posedge clk) begin
        core_pipe[0] <= teaEncrypt(core_plaintext, core_key);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_ciphertext = core_pipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [63:0] p0, input logic [127:0] k0,
                                 input logic v1, input logic [63:0] p1, input logic [127:0] k1,
                                 input logic mr);
        s0_valid = v0; s0_plaintext = p0; s0_key = k0;
        s1_valid = v1; s1_plaintext = p1; s1_key = k1;
        m_ready = mr;
    endtask

    // Called at the negedge: records issued blocks and checks every pop against issue order.
    task automatic observe();
        logic [63:0]  pt;
        logic [127:0] key;
        if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) begin
            pt  = s1_ready ? s1_plaintext : s0_plaintext;
            key = s1_ready ? s1_key : s0_key;
            checkOutput("core_pt", {64'h0, core_plaintext}, {64'h0, pt});
            checkOutput("core_key", core_key, key);
            exp_q.push_back({s1_ready, teaEncrypt(pt, key)});
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out", {127'h0, m_valid}, 128'h0);
            end else begin
                checkOutput("out_order", {63'h0, m_src, m_ciphertext}, {63'h0, exp_q[0]});
                void'(exp_q.pop_front());
                pop_count++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int limit);
        applyStimulus(0, '0, '0, 0, '0, '0, 1);
        for (int c = 0; c < limit && exp_q.size() != 0; c++) step();
        checkOutput("drain_left", exp_q.size(), 0);
        @(negedge clk);
        checkOutput("drain_busy", {127'h0, busy}, 128'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   cyc, issues, stale;
        logic exp_grant;
        logic [127:0] key_a, key_b;
        key_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        key_b = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;

        // Reset state, with a request present to show ready stays low.
        applyStimulus(1, '0, '0, 1, '0, '0, 0);
        repeat (2) @(negedge clk);
        checkOutput("rst_m_valid", {127'h0, m_valid}, 128'h0);
        checkOutput("rst_m_ct", {64'h0, m_ciphertext}, 128'h0);
        checkOutput("rst_m_src", {127'h0, m_src}, 128'h0);
        checkOutput("rst_busy", {127'h0, busy}, 128'h0);
        checkOutput("rst_ready", {126'h0, s1_ready, s0_ready}, 128'h0);
        @(posedge clk); #1;
        applyStimulus(0, '0, '0, 0, '0, '0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single all-zero block: known TEA vector and issue-to-output latency.
        checkOutput("tea_vector", {64'h0, teaEncrypt(64'h0, 128'h0)}, {64'h0, 64'h41EA3A0A94BAA940});
        applyStimulus(1, 64'h0, 128'h0, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("t1_s0_ready", {127'h0, s0_ready}, 128'h1);
        observe();
        @(posedge clk); #1;
        applyStimulus(0, '0, '0, 0, '0, '0, 0);
        cyc = 1;
        @(negedge clk);
        while (!m_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t1_latency", cyc, 34);
        checkOutput("t1_ct", {64'h0, m_ciphertext}, {64'h0, 64'h41EA3A0A94BAA940});
        checkOutput("t1_src", {127'h0, m_src}, 128'h0);
        checkOutput("t1_busy", {127'h0, busy}, 128'h1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        observe();
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        checkOutput("t1_empty", {127'h0, m_valid}, 128'h0);
        checkOutput("t1_idle", {127'h0, busy}, 128'h0);
        @(posedge clk); #1;

        // Both requesters continuously: alternating grants starting with s0, credit-limited.
        doReset();
        exp_grant = 1'b0;
        issues = 0;
        pop_count = 0;
        for (int c = 0; c < 80; c++) begin
            applyStimulus(1, 64'h5000_0000_0000_0000 + 64'(c), key_a,
                          1, 64'h6000_0000_0000_0000 + 64'(c), key_b, 1);
            @(negedge clk);
            if (s0_ready || s1_ready) begin
                checkOutput("t2_grant", {126'h0, s1_ready, s0_ready},
                            exp_grant ? 128'h2 : 128'h1);
                exp_grant = ~exp_grant;
                issues++;
            end
            observe();
            @(posedge clk); #1;
        end
        checkOutput("t2_issues", issues, 12);
        checkOutput("t2_pops", pop_count, 8);
        drain(120);

        // Consumer stalled: exactly four credits, then one pop frees one issue.
        issues = 0;
        for (int c = 0; c < 50; c++) begin
            applyStimulus(1, 64'h7000_0000_0000_0000 + 64'(c), key_b, 0, '0, '0, 0);
            @(negedge clk);
            if (s0_ready) issues++;
            observe();
            @(posedge clk); #1;
        end
        checkOutput("t3_issues", issues, 4);
        checkOutput("t3_stalled", {127'h0, s0_ready}, 128'h0);
        checkOutput("t3_full_valid", {127'h0, m_valid}, 128'h1);
        applyStimulus(1, 64'h7100_0000_0000_0000, key_b, 0, '0, '0, 1);
        @(negedge clk);
        checkOutput("t3_pulse_ready", {127'h0, s0_ready}, 128'h0);
        observe();
        @(posedge clk); #1;
        applyStimulus(1, 64'h7200_0000_0000_0000, key_b, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("t3_reissue", {127'h0, s0_ready}, 128'h1);
        observe();
        @(posedge clk); #1;
        applyStimulus(1, 64'h7300_0000_0000_0000, key_b, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("t3_stall_again", {127'h0, s0_ready}, 128'h0);
        observe();
        @(posedge clk); #1;

        // One pop leaves one credit; then issue and pop together must keep it at one.
        applyStimulus(0, '0, '0, 0, '0, '0, 1);
        step();
        applyStimulus(1, 64'h7400_0000_0000_0000, key_a, 0, '0, '0, 1);
        @(negedge clk);
        checkOutput("t4_issue_pop_ready", {127'h0, s0_ready}, 128'h1);
        checkOutput("t4_issue_pop_valid", {127'h0, m_valid}, 128'h1);
        observe();
        @(posedge clk); #1;
        applyStimulus(1, 64'h7500_0000_0000_0000, key_a, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("t4_credit_kept", {127'h0, s0_ready}, 128'h1);
        observe();
        @(posedge clk); #1;
        applyStimulus(1, 64'h7600_0000_0000_0000, key_a, 0, '0, '0, 0);
        @(negedge clk);
        checkOutput("t4_credit_used", {127'h0, s0_ready}, 128'h0);
        observe();
        @(posedge clk); #1;
        drain(120);

        // Two buffered and two in flight, then reset mid-operation.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1, 64'h8000_0000_0000_0000 + 64'(c), key_a, 0, '0, '0, 0);
            step();
        end
        applyStimulus(0, '0, '0, 0, '0, '0, 0);
        for (int c = 0; c < 36; c++) step();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(0, '0, '0, 1, 64'h8100_0000_0000_0000 + 64'(c), key_b, 0);
            step();
        end
        applyStimulus(1, '0, '0, 0, '0, '0, 0);
        repeat (10) step();
        checkOutput("t5_pre_valid", {127'h0, m_valid}, 128'h1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("t5_rst_valid", {127'h0, m_valid}, 128'h0);
        checkOutput("t5_rst_ct", {64'h0, m_ciphertext}, 128'h0);
        checkOutput("t5_rst_busy", {127'h0, busy}, 128'h0);
        checkOutput("t5_rst_ready", {127'h0, s0_ready}, 128'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        applyStimulus(0, '0, '0, 0, '0, '0, 1);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_valid) stale++;
            @(posedge clk); #1;
        end
        checkOutput("t5_no_stale", stale, 0);
        applyStimulus(1, 64'h9000_0000_0000_0000, key_a, 1, 64'h9100_0000_0000_0000, key_b, 0);
        @(negedge clk);
        checkOutput("t5_tie_s0", {126'h0, s1_ready, s0_ready}, 128'h1);
        observe();
        @(posedge clk); #1;

        // Lone s1 keeps winning back-to-back; the next tie goes to s0.
        applyStimulus(0, '0, '0, 1, 64'h9200_0000_0000_0000, key_b, 0);
        @(negedge clk);
        checkOutput("t6_s1_first", {126'h0, s1_ready, s0_ready}, 128'h2);
        observe();
        @(posedge clk); #1;
        applyStimulus(0, '0, '0, 1, 64'h9300_0000_0000_0000, key_a, 0);
        @(negedge clk);
        checkOutput("t6_s1_again", {126'h0, s1_ready, s0_ready}, 128'h2);
        observe();
        @(posedge clk); #1;
        applyStimulus(1, 64'h9400_0000_0000_0000, key_b, 1, 64'h9500_0000_0000_0000, key_a, 0);
        @(negedge clk);
        checkOutput("t6_tie_after_s1", {126'h0, s1_ready, s0_ready}, 128'h1);
        observe();
        @(posedge clk); #1;
        issues = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1, 64'h9600_0000_0000_0000 + 64'(c), key_a, 0, '0, '0, 0);
            @(negedge clk);
            if (s0_ready) issues++;
            observe();
            @(posedge clk); #1;
        end
        checkOutput("t6_credits_out", issues, 0);
        drain(120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
